// File: rtl/i2c_arbiter.sv
// Two-port arbiter in front of a single I2C master: captures one command per port,
// grants round-robin, and lets a locked owner keep the bus across multi-command transactions.
module i2c_arbiter #(
    parameter int HOLD_TO = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m0_req,
    input  logic       m1_req,
    input  logic       m0_lock,
    input  logic       m1_lock,
    input  logic [3:0] m0_cmd,
    input  logic [3:0] m1_cmd,
    input  logic [7:0] m0_wr_data,
    input  logic [7:0] m1_wr_data,
    output logic [7:0] m0_rd_data,
    output logic [7:0] m1_rd_data,
    output logic       m0_done,
    output logic       m1_done,
    output logic       req,
    output logic [3:0] cmd,
    output logic [7:0] wr_data,
    input  logic [7:0] rd_data,
    input  logic       done,
    output logic       owner,
    output logic       busy
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_TO - 1);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]  cmd_q;
    logic [7:0]  wr_data_q;

    logic        port_req  [2];
    logic        port_lock [2];
    logic [3:0]  port_cmd  [2];
    logic [7:0]  port_wd   [2];

    logic        pend_q    [2];
    logic        done_q    [2];
    logic [3:0]  cap_cmd_q [2];
    logic [7:0]  cap_wd_q  [2];
    logic [7:0]  rd_q      [2];

    assign port_req[0]  = m0_req;
    assign port_req[1]  = m1_req;
    assign port_lock[0] = m0_lock;
    assign port_lock[1] = m1_lock;
    assign port_cmd[0]  = m0_cmd;
    assign port_cmd[1]  = m1_cmd;
    assign port_wd[0]   = m0_wr_data;
    assign port_wd[1]   = m1_wr_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic is_owner;
            logic resp_hit;

            assign is_owner = (owner_q == 1'(gi));
            assign resp_hit = (state_q == S_WAIT) && done && is_owner;

            // A fresh request in the issue cycle wins over the clear.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pend_q[gi]    <= 1'b0;
                    cap_cmd_q[gi] <= '0;
                    cap_wd_q[gi]  <= '0;
                    rd_q[gi]      <= '0;
                    done_q[gi]    <= 1'b0;
                end else begin
                    if (port_req[gi]) begin
                        pend_q[gi]    <= 1'b1;
                        cap_cmd_q[gi] <= port_cmd[gi];
                        cap_wd_q[gi]  <= port_wd[gi];
                    end else if ((state_q == S_ISSUE) && is_owner) begin
                        pend_q[gi] <= 1'b0;
                    end
                    done_q[gi] <= resp_hit;
                    if (resp_hit) begin
                        rd_q[gi] <= rd_data;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pend_q[0] && pend_q[1]) begin
                    owner_d = ~owner_q;
                    state_d = S_ISSUE;
                end else if (pend_q[0]) begin
                    owner_d = 1'b0;
                    state_d = S_ISSUE;
                end else if (pend_q[1]) begin
                    owner_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (done) begin
                    state_d    = port_lock[owner_q] ? S_HOLD : S_IDLE;
                    hold_cnt_d = '0;
                end
            end
            S_HOLD: begin
                // Locked owner skips arbitration; the other port only accumulates pending.
                if (pend_q[owner_q]) begin
                    state_d = S_ISSUE;
                end else if (!port_lock[owner_q] || (hold_cnt_q == HOLD_LAST)) begin
                    state_d = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b1;
            hold_cnt_q <= '0;
            cmd_q      <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            if (state_d == S_ISSUE) begin
                cmd_q     <= cap_cmd_q[owner_d];
                wr_data_q <= cap_wd_q[owner_d];
            end
        end
    end

    assign req        = (state_q == S_ISSUE);
    assign cmd        = cmd_q;
    assign wr_data    = wr_data_q;
    assign owner      = owner_q;
    assign busy       = (state_q != S_IDLE);
    assign m0_rd_data = rd_q[0];
    assign m1_rd_data = rd_q[1];
    assign m0_done    = done_q[0];
    assign m1_done    = done_q[1];

endmodule

// File: tb/tb_i2c_arbiter.sv
// Scoreboard bench for i2c_arbiter: requester agents, an I2C-master responder model and
// a monitor that matches issued commands and returned bytes against bench-side expectations.
module tb_i2c_arbiter;
    localparam int HOLD_TO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       m0_req = 1'b0, m1_req = 1'b0, m0_lock = 1'b0, m1_lock = 1'b0;
    logic [3:0] m0_cmd = '0, m1_cmd = '0;
    logic [7:0] m0_wr_data = '0, m1_wr_data = '0;
    logic [7:0] m0_rd_data, m1_rd_data;
    logic       m0_done, m1_done;
    logic       req;
    logic [3:0] cmd;
    logic [7:0] wr_data;
    logic [7:0] rd_data = '0;
    logic       done = 1'b0;
    logic       owner, busy;

    i2c_arbiter #(.HOLD_TO(HOLD_TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_cmd(m0_cmd), .m1_cmd(m1_cmd), .m0_wr_data(m0_wr_data), .m1_wr_data(m1_wr_data),
        .m0_rd_data(m0_rd_data), .m1_rd_data(m1_rd_data), .m0_done(m0_done), .m1_done(m1_done),
        .req(req), .cmd(cmd), .wr_data(wr_data), .rd_data(rd_data), .done(done),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic void fail(input string name);
        chk_cnt++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    // Bench model: one outstanding command per port, expected responses, issue log.
    typedef struct {int port; logic [7:0] rd; int cyc;} rdexp_t;
    rdexp_t     exp_q[$];
    logic [3:0] out_cmd [2];
    logic [7:0] out_wd  [2];
    bit         out_v   [2];
    logic [7:0] exp_last_rd [2];
    int         iss_port[$];
    int         iss_cyc[$];
    int         mdone_seen = 0;

    bit         resp_valid = 0;
    int         resp_cnt, resp_port;
    logic [7:0] resp_rd;
    logic [7:0] forced_rd_q[$];
    int         slave_delay = 2;
    bit         spur_pending = 0;
    logic [7:0] spur_val = 8'hEE;

    initial begin
        out_v[0] = 0; out_v[1] = 0;
        exp_last_rd[0] = '0; exp_last_rd[1] = '0;
    end

    // Responder standing in for the I2C master; rd_data is noise except when done is high.
    always @(posedge clk) begin
        #1;
        done    = 1'b0;
        rd_data = 8'($urandom);
        if (spur_pending) begin
            done = 1'b1; rd_data = spur_val; spur_pending = 0;
        end else if (resp_valid) begin
            if (resp_cnt == 0) begin
                done = 1'b1; rd_data = resp_rd;
                exp_q.push_back('{resp_port, resp_rd, cyc + 1});
                resp_valid = 0;
            end else begin
                resp_cnt--;
            end
        end
    end

    int     mp;
    rdexp_t me;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (req === 1'b1) begin
                mp = -1;
                for (int i = 0; i < 2; i++)
                    if (out_v[i] && out_cmd[i] == cmd && out_wd[i] == wr_data) mp = i;
                if (mp < 0) begin
                    fail("issue_match");
                end else begin
                    chk("issue_owner", 32'(owner), 32'(mp));
                    out_v[mp] = 0;
                    iss_port.push_back(mp);
                    iss_cyc.push_back(cyc);
                    resp_port  = mp;
                    resp_rd    = (forced_rd_q.size() > 0) ? forced_rd_q.pop_front() : 8'($urandom);
                    resp_cnt   = (slave_delay < 0) ? int'($urandom_range(0, 4)) : slave_delay;
                    resp_valid = 1;
                end
            end
            if (m0_done === 1'b1 || m1_done === 1'b1) begin
                mdone_seen++;
                if (exp_q.size() == 0) begin
                    fail("done_spurious");
                end else begin
                    me = exp_q.pop_front();
                    chk("done_port", {30'd0, m1_done, m0_done}, (me.port == 1) ? 32'd2 : 32'd1);
                    chk("done_cycle", 32'(cyc), 32'(me.cyc));
                    chk("rd_data", (me.port == 1) ? 32'(m1_rd_data) : 32'(m0_rd_data), 32'(me.rd));
                    chk("other_rd", (me.port == 1) ? 32'(m0_rd_data) : 32'(m1_rd_data),
                        32'(exp_last_rd[1 - me.port]));
                    exp_last_rd[me.port] = me.rd;
                end
            end
        end
    end

    task automatic send(input int p, input logic [3:0] c, input logic [7:0] d, output int t);
        @(posedge clk); #1;
        t = cyc;
        out_cmd[p] = c; out_wd[p] = d; out_v[p] = 1;
        if (p == 0) begin m0_req = 1; m0_cmd = c; m0_wr_data = d; end
        else        begin m1_req = 1; m1_cmd = c; m1_wr_data = d; end
        @(posedge clk); #1;
        if (p == 0) m0_req = 0; else m1_req = 0;
    endtask

    task automatic wait_done(input int p, output int dcyc);
        dcyc = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if ((p == 0 && m0_done === 1'b1) || (p == 1 && m1_done === 1'b1)) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) fail($sformatf("done_timeout_port%0d", p));
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        resp_valid = 0; spur_pending = 0;
        exp_q.delete(); forced_rd_q.delete();
        out_v[0] = 0; out_v[1] = 0;
        exp_last_rd[0] = '0; exp_last_rd[1] = '0;
        m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0;
        #1;
        chk("rst_req", 32'(req), 0);
        chk("rst_cmd", 32'(cmd), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_m0_done", 32'(m0_done), 0);
        chk("rst_m1_done", 32'(m1_done), 0);
        chk("rst_m0_rd", 32'(m0_rd_data), 0);
        chk("rst_m1_rd", 32'(m1_rd_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic agent(input int p, input int n);
        int t, d;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            if (p == 0) m0_lock = ($urandom_range(0, 2) == 0) && (k != n - 1);
            else        m1_lock = ($urandom_range(0, 2) == 0) && (k != n - 1);
            send(p, 4'($urandom), {7'($urandom), 1'(p)}, t);
            wait_done(p, d);
        end
        @(negedge clk);
        if (p == 0) m0_lock = 0; else m1_lock = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int t0, t1, d0, d1, base, seen0;
    int exp_order[4];

    initial begin
        do_reset();

        // Single command: latency and response routing.
        slave_delay = 2;
        forced_rd_q.push_back(8'h5C);
        send(0, 4'h1, 8'hA0, t0);
        wait_done(0, d0);
        chk("single_latency", 32'(iss_cyc[$]), 32'(t0 + 2));
        chk("single_port", 32'(iss_port[$]), 0);
        chk("single_m0_rd", 32'(m0_rd_data), 32'h5C);
        chk("single_m1_rd", 32'(m1_rd_data), 0);

        // Ties after reset alternate starting with port 0.
        do_reset();
        base = iss_port.size();
        fork
            send(0, 4'h2, 8'h20, t0);
            send(1, 4'h2, 8'h21, t1);
        join
        fork
            wait_done(0, d0);
            wait_done(1, d1);
        join
        fork
            send(0, 4'h2, 8'h22, t0);
            send(1, 4'h2, 8'h23, t1);
        join
        fork
            wait_done(0, d0);
            wait_done(1, d1);
        join
        exp_order = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++)
            chk($sformatf("tie_order%0d", i), 32'(iss_port[base + i]), 32'(exp_order[i]));

        // Locked owner keeps the grant for three commands.
        base = iss_port.size();
        m1_lock = 1;
        fork
            begin
                send(1, 4'h5, 8'h51, t1); wait_done(1, d1);
                send(1, 4'h6, 8'h61, t1); wait_done(1, d1);
                send(1, 4'h7, 8'h71, t1); wait_done(1, d1);
                m1_lock = 0;
            end
            begin
                repeat (3) @(negedge clk);
                send(0, 4'h8, 8'h80, t0); wait_done(0, d0);
            end
        join
        exp_order = '{1, 1, 1, 0};
        for (int i = 0; i < 4; i++)
            chk($sformatf("lock_order%0d", i), 32'(iss_port[base + i]), 32'(exp_order[i]));

        // Silent locked owner loses the grant after HOLD_TO cycles.
        m0_lock = 1;
        fork
            send(0, 4'h3, 8'h30, t0);
            begin @(posedge clk); send(1, 4'h4, 8'h41, t1); end
        join
        wait_done(0, d0);
        base = iss_port.size();
        repeat (4) @(negedge clk);
        chk("hold_busy", 32'(busy), 1);
        chk("hold_no_issue", 32'(iss_port.size()), 32'(base));
        wait_done(1, d1);
        chk("timeout_issue_cycle", 32'(iss_cyc[$]), 32'(d0 + HOLD_TO + 1));
        chk("timeout_port", 32'(iss_port[$]), 1);
        m0_lock = 0;

        // Done with nobody waiting is ignored.
        repeat (3) @(negedge clk);
        seen0 = mdone_seen;
        spur_pending = 1;
        repeat (4) @(negedge clk);
        chk("spur_m0_rd", 32'(m0_rd_data), 32'(exp_last_rd[0]));
        chk("spur_m1_rd", 32'(m1_rd_data), 32'(exp_last_rd[1]));
        chk("spur_no_done", 32'(mdone_seen), 32'(seen0));
        chk("spur_idle", 32'(busy), 0);

        // Reset in the middle of a transaction drops it.
        slave_delay = 10;
        send(0, 4'h9, 8'h90, t0);
        repeat (3) @(negedge clk);
        chk("midwait_busy", 32'(busy), 1);
        seen0 = mdone_seen;
        do_reset();
        slave_delay = 1;
        repeat (15) @(negedge clk);
        chk("midwait_no_done", 32'(mdone_seen), 32'(seen0));
        forced_rd_q.push_back(8'h3C);
        send(0, 4'hA, 8'hA2, t0);
        wait_done(0, d0);
        chk("post_reset_latency", 32'(iss_cyc[$]), 32'(t0 + 2));
        chk("post_reset_rd", 32'(m0_rd_data), 32'h3C);

        // Randomised traffic from both requesters.
        slave_delay = -1;
        fork
            agent(0, 25);
            agent(1, 25);
        join
        repeat (20) @(negedge clk);
        chk("final_exp_empty", 32'(exp_q.size()), 0);
        chk("final_outstanding", 32'(int'(out_v[0]) + int'(out_v[1])), 0);
        chk("final_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
